// File: rtl/hr_mux_pkg.sv
// Shared types and constants for the half-rate parametric serialiser.
package hr_mux_pkg;

  // Source selected at each word-capture edge.
  typedef enum logic [1:0] {
    ModeData    = 2'b00,
    ModePrbs7   = 2'b01,
    ModeClkPat  = 2'b10,
    ModeSquelch = 2'b11
  } mode_e;

  // x^7 + x^6 + 1: feedback is state[6] ^ state[5].
  localparam logic [6:0] Prbs7Taps = 7'h60;
  localparam logic [6:0] Prbs7Seed = 7'h7F;

  // Legal when DIN_W / DOUT_W is an exact power of two, at least 2.
  function automatic bit ratio_legal(int unsigned din_w, int unsigned dout_w);
    int unsigned r;
    if (dout_w == 0) return 1'b0;
    if ((din_w % dout_w) != 0) return 1'b0;
    r = din_w / dout_w;
    if (r < 2) return 1'b0;
    return ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/prbs7_par_gen.sv
// Parallel PRBS7 generator: presents the next W sequence bits and advances W steps when enabled.
module prbs7_par_gen
  import hr_mux_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] bits
);

  logic [6:0] state_q;
  logic [6:0] state_adv;

  // Unroll W serial LFSR steps; bit i of the output is the i-th generated bit.
  always_comb begin
    logic [6:0] s;
    logic       b;
    bits = '0;
    s    = state_q;
    b    = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      b       = ^(s & Prbs7Taps);
      bits[i] = b;
      s       = {s[5:0], b};
    end
    state_adv = s;
  end

  // State register; an all-zero lock-up state is replaced by the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Prbs7Seed;
    end else if (state_q == 7'h00) begin
      state_q <= Prbs7Seed;
    end else if (en) begin
      state_q <= state_adv;
    end
  end

endmodule

// File: rtl/hr_param_mux_top.sv
// Parametric DIN_W:DOUT_W serialiser feeding a downstream 2:1 half-rate stage.
module hr_param_mux_top
  import hr_mux_pkg::*;
#(
  parameter int unsigned DIN_W     = 16,
  parameter int unsigned DOUT_W    = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  din,
  input  logic [1:0]        mode,
  output logic              clk_prbs,
  output logic              load,
  output logic [DOUT_W-1:0] dout
);

  localparam int unsigned Ratio = DIN_W / DOUT_W;
  localparam int unsigned CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(Ratio - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Ratio / 2);

  if (!ratio_legal(DIN_W, DOUT_W)) begin : g_bad_ratio
    $error("hr_param_mux_top: DIN_W/DOUT_W must be a power of two >= 2");
  end

  logic [CntW-1:0]   cnt;
  logic [CntW-1:0]   cnt_next;
  logic [DIN_W-1:0]  shadow;
  logic [DIN_W-1:0]  src;
  logic [DIN_W-1:0]  prbs_bits;
  logic [DIN_W-1:0]  clk_pat;
  logic [DOUT_W-1:0] slice;
  logic              cap;
  logic              prbs_en;
  mode_e             mode_s;

  // Even slices all-ones, odd slices all-zeros, so the lane toggles every cycle.
  for (genvar s = 0; s < int'(Ratio); s++) begin : g_clk_pat
    assign clk_pat[s*DOUT_W +: DOUT_W] = ((s % 2) == 0) ? {DOUT_W{1'b1}} : {DOUT_W{1'b0}};
  end

  prbs7_par_gen #(
    .W (DIN_W)
  ) u_prbs (
    .clk  (clk),
    .rst  (rst),
    .en   (prbs_en),
    .bits (prbs_bits)
  );

  // Capture decode, slot advance and source selection.
  always_comb begin
    mode_s   = mode_e'(mode);
    cap      = (cnt == CntMax);
    cnt_next = cap ? '0 : cnt + CntW'(1);
    prbs_en  = cap && (mode_s == ModePrbs7);
    src      = '0;
    unique case (mode_s)
      ModeData:    src = din;
      ModePrbs7:   src = prbs_bits;
      ModeClkPat:  src = clk_pat;
      ModeSquelch: src = '0;
      default:     src = '0;
    endcase
  end

  // Pick the slice for the current slot from the word already held in shadow.
  always_comb begin
    logic [CntW-1:0] idx;
    idx   = MSB_FIRST ? (CntMax - cnt) : cnt;
    slice = '0;
    for (int s = 0; s < int'(Ratio); s++) begin
      if (idx == CntW'(s)) slice = shadow[s*DOUT_W +: DOUT_W];
    end
  end

  // All datapath state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      shadow   <= '0;
      dout     <= '0;
      load     <= 1'b0;
      clk_prbs <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      dout     <= slice;
      load     <= cap;
      clk_prbs <= (cnt_next < CntHalf);
      if (cap) shadow <= src;
    end
  end

endmodule

// File: doc/hr_param_mux_top.md
HR_PARAM_MUX_TOP -- requirements
Module: hr_param_mux_top

Interface
REQ-001 Parameter DIN_W, default 16, parallel input word width in bits.
REQ-002 Parameter DOUT_W, default 4, output lanes per clk cycle; DIN_W/DOUT_W = RATIO SHALL be a power of two, at least 2; elaboration error otherwise.
REQ-003 Parameter MSB_FIRST, default 0; 1 reverses slice transmit order.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  half-rate clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 din  in  DIN_W  parallel data word.
REQ-008 mode  in  2  source select: 00 DATA, 01 PRBS7, 10 CLKPAT, 11 SQUELCH.
REQ-009 clk_prbs  out  1  divide-by-RATIO word clock for the upstream data source.
REQ-010 load  out  1  one-cycle pulse marking the word-capture edge.
REQ-011 dout  out  DOUT_W  serialised slice, one per clk cycle; downstream 2:1 stage doubles the rate.

Function
REQ-012 Slot counter cnt, range 0..RATIO-1, SHALL increment each cycle and wrap from RATIO-1 to 0.
REQ-013 At an edge where cnt==RATIO-1, shadow register SHALL capture the source word selected by mode; mode is sampled only at this edge, so a mid-word change takes effect from the next word.
REQ-014 At every edge, dout SHALL take slice cnt of shadow before that edge updates it; slice s = shadow[s*DOUT_W +: DOUT_W], or slice RATIO-1-s when MSB_FIRST=1.
REQ-015 Latency: a word captured at edge E presents slice 0 after edge E+1 and slice k after edge E+1+k; no slice is skipped or repeated.
REQ-016 load SHALL be registered high for exactly the cycle following each capture edge.
REQ-017 clk_prbs SHALL be registered: 1 when the post-edge cnt < RATIO/2, else 0; 50% duty, period RATIO clk cycles, rising on each capture edge.
REQ-018 DATA: source = din.
REQ-019 PRBS7: source = the next DIN_W bits of PRBS7 (x^7+x^6+1), bit i to source[i]; the generator advances DIN_W steps only on capture edges in PRBS7 mode and holds otherwise.
REQ-020 CLKPAT: source slices alternate all-ones (even s) / all-zeros (odd s), so dout toggles every cycle.
REQ-021 SQUELCH: source = all zeros.
REQ-022 PRBS7 state SHALL never reach all-zeros; if it is ever detected, the state SHALL reload the seed on the next edge.

Reset
REQ-023 While rst=1: cnt=0, shadow=0, dout=0, load=0, clk_prbs=0, PRBS7 state = seed 7'h7F.
REQ-024 Reset asserted mid-word SHALL abort that word; after release, the first capture occurs at the edge where cnt reaches RATIO-1, and until then dout SHALL be 0.
REQ-025 The first edge after release SHALL move cnt 0->1 and set clk_prbs per REQ-017.

Structure
REQ-026 Package hr_mux_pkg SHALL hold the mode enum, PRBS7 tap/seed constants and the RATIO legality check function.
REQ-027 Sub-module prbs7_par_gen (parameter W) SHALL implement the W-step parallel PRBS7 advance, with enable and synchronous reset.
REQ-028 The top SHALL instantiate exactly one prbs7_par_gen with W=DIN_W; all other logic is local.

Verification
REQ-029 Defaults, DATA, din=16'hA5C3 held -> dout repeats 3,C,5,A; load high once per 4 cycles; clk_prbs = 1100 pattern.
REQ-030 MSB_FIRST=1, din=16'hA5C3 -> dout repeats A,5,C,3.
REQ-031 DIN_W=32, DOUT_W=4, din=32'h76543210 -> dout 0..7 repeating; clk_prbs period 8, high 4.
REQ-032 PRBS7 for 200 words -> reference model matches every bit; 127-bit period; state never all-zero; switching to DATA freezes the state.
REQ-033 rst pulsed when cnt==2 mid-word -> dout=0 until first capture, cnt restarts at 0, old word never emitted.
REQ-034 mode DATA->CLKPAT at cnt==1 -> current word completes as data; next word dout = F,0,F,0; SQUELCH then gives dout=0.
